// File: rtl/par_serial_tx_pkg.sv
// Shared constants for the serial transmit stage behind the 4:1 lane mux.
// Symbol values and FSM encoding live here so the line format is defined once.
package par_serial_tx_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] COM_SYM  = 8'hBC;
    localparam logic [BYTE_W-1:0] IDLE_SYM = 8'h7C;

    localparam logic [0:0] ST_ALIGN  = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Byte to put on the line for one slot.
    function automatic logic [BYTE_W-1:0] slot_byte(
        input logic              active,
        input logic              valid,
        input logic [BYTE_W-1:0] data,
        input logic [BYTE_W-1:0] com,
        input logic [BYTE_W-1:0] idle
    );
        logic [BYTE_W-1:0] b;
        b = com;
        if (active) begin
            b = valid ? data : idle;
        end
        return b;
    endfunction

endpackage

// File: rtl/piso_shift8.sv
// 8-bit parallel-in serial-out register, shifts left, MSB on the line.
// Reset clears the register so the line drops to 0 immediately.
module piso_shift8
    import par_serial_tx_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              load,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] d,
    output logic              data_out
);

    logic [BYTE_W-1:0] q;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= {q[BYTE_W-2:0], 1'b0};
        end
    end

    assign data_out = q[BYTE_W-1];

endmodule

// File: rtl/par_serial_tx.sv
// Serialises the muxed byte stream MSB-first, one bit per clk_32f cycle,
// preceded by a COM preamble and with IDLE filling empty slots.
module par_serial_tx #(
    parameter int COM_COUNT = 4,
    parameter logic [par_serial_tx_pkg::BYTE_W-1:0] COM_SYM =
        par_serial_tx_pkg::COM_SYM,
    parameter logic [par_serial_tx_pkg::BYTE_W-1:0] IDLE_SYM =
        par_serial_tx_pkg::IDLE_SYM
) (
    input  logic                               clk_32f,
    input  logic                               reset,
    input  logic [par_serial_tx_pkg::BYTE_W-1:0] data_in,
    input  logic                               valid_in,
    output logic                               data_out,
    output logic                               load_strb,
    output logic                               aligned,
    output logic                               idle_out
);

    import par_serial_tx_pkg::*;

    logic [2:0]        bit_cnt;
    logic [3:0]        com_cnt;
    logic [0:0]        state;
    logic              com_last;
    logic [BYTE_W-1:0] next_byte;

    // bit_cnt==7 marks the slot boundary; the next edge loads a byte.
    assign load_strb = (bit_cnt == 3'd7);
    assign com_last  = (com_cnt == 4'(COM_COUNT - 1));

    always_comb begin
        next_byte = slot_byte(state == ST_ACTIVE, valid_in, data_in,
                              COM_SYM, IDLE_SYM);
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            bit_cnt <= 3'd7;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state    <= ST_ALIGN;
            com_cnt  <= 4'd0;
            aligned  <= 1'b0;
            idle_out <= 1'b0;
        end else if (load_strb) begin
            unique case (state)
                ST_ALIGN: begin
                    com_cnt <= com_cnt + 4'd1;
                    if (com_last) begin
                        state   <= ST_ACTIVE;
                        aligned <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    idle_out <= !valid_in;
                end
            endcase
        end
    end

    piso_shift8 u_piso (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .load     (load_strb),
        .shift_en (1'b1),
        .d        (next_byte),
        .data_out (data_out)
    );

endmodule
